// File: rtl/fma_arb_pkg.sv
// Shared types and constants for the FMA share arbiter.
// Optional statistics counters are enabled with FMA_ARB_STAT_EN.
package fma_arb_pkg;

    localparam int FP32_W      = 32;
    localparam int FMA_LAT_DEF = 5;
    // Widest requester id supported (NREQ up to 8)
    localparam int ID_MAX_W    = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic                vld;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fma_arb_rsp_fifo.sv
// First-word-fall-through response FIFO with occupancy count.
// Output data reads as zero while the FIFO is empty.
module fma_arb_rsp_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             not_empty;
    logic             do_rd;

    assign not_empty = (count != '0);
    assign do_rd     = rd_en && not_empty;
    assign rd_data   = not_empty ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Writers never exceed DEPTH: the credit counter upstream bounds them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !do_rd) begin
                count <= count + CW'(1);
            end else if (!wr_en && do_rd) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fma_share_arbiter.sv
// Round-robin sharing of one pipelined FP32 FMA between NREQ requesters.
// Define FMA_ARB_STAT_EN to add the stat_issued / stat_stall counters.
module fma_share_arbiter
    import fma_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int FMA_LAT = FMA_LAT_DEF,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*FP32_W-1:0]   req_a,
    input  logic [NREQ*FP32_W-1:0]   req_b,
    input  logic [NREQ*FP32_W-1:0]   req_c,
    output logic [FP32_W-1:0]        fma_a,
    output logic [FP32_W-1:0]        fma_b,
    output logic [FP32_W-1:0]        fma_c,
    output logic                     fma_rst,
    input  logic [FP32_W-1:0]        fma_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [FP32_W-1:0]        rsp_result,
    input  logic                     flush_req,
    output logic                     flush_done
`ifdef FMA_ARB_STAT_EN
    ,
    output logic [31:0]              stat_issued,
    output logic [31:0]              stat_stall
`endif
);

    localparam int IDW = $clog2(NREQ);
    localparam int SW  = IDW + 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int TW  = IDW + FP32_W;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);
    localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   cand;
    logic [SW-1:0]    sum;
    logic             found;
    logic             can_issue;
    logic             issue;
    logic             pop;
    logic [CW-1:0]    credit;
    logic [CW-1:0]    fifo_count;
    logic [TW-1:0]    fifo_rd;
    logic [FP32_W-1:0] op_a;
    logic [FP32_W-1:0] op_b;
    logic [FP32_W-1:0] op_c;
    tag_t             tag_pipe [FMA_LAT+1];
    tag_t             tail;
    logic             unused_tag;

    assign fma_rst    = ~rst_n;
    assign rsp_valid  = (fifo_count != '0);
    assign pop        = rsp_valid && rsp_ready;
    // A pop frees a slot this cycle, so a full credit can still issue
    assign can_issue  = (state != DRAIN) && ((credit < FULL) || pop);
    assign issue      = found && can_issue;
    assign rsp_id     = fifo_rd[TW-1 -: IDW];
    assign rsp_result = fifo_rd[FP32_W-1:0];
    assign tail       = tag_pipe[FMA_LAT];
    assign unused_tag = ^tail.id;

    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        cand   = '0;
        sum    = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + SW'(k);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            cand = sum[IDW-1:0];
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                gnt_id = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        op_a = '0;
        op_b = '0;
        op_c = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_id == IDW'(k)) begin
                op_a = req_a[FP32_W*k +: FP32_W];
                op_b = req_b[FP32_W*k +: FP32_W];
                op_c = req_c[FP32_W*k +: FP32_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            fma_a  <= '0;
            fma_b  <= '0;
            fma_c  <= '0;
        end else if (issue) begin
            rr_ptr <= (gnt_id == LAST) ? '0 : gnt_id + IDW'(1);
            fma_a  <= op_a;
            fma_b  <= op_b;
            fma_c  <= op_c;
        end
    end

    // The FMA carries no tags; this pipe shadows it one stage longer
    // so the tail lines up with the registered fma_result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= FMA_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0].vld <= issue;
            tag_pipe[0].id  <= ID_MAX_W'(gnt_id);
            for (int i = 1; i <= FMA_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    fma_arb_rsp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TW)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tail.vld),
        .wr_data ({tail.id[IDW-1:0], fma_result}),
        .rd_en   (rsp_ready),
        .rd_data (fifo_rd),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= '0;
        end else if (issue && !pop) begin
            credit <= credit + CW'(1);
        end else if (!issue && pop) begin
            credit <= credit - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        flush_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (flush_req) begin
                    state_nxt = DRAIN;
                end else if (issue) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (flush_req) begin
                    state_nxt = DRAIN;
                end else if (credit == '0 && !issue) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (credit == '0) begin
                    state_nxt  = IDLE;
                    flush_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FMA_ARB_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (|req_valid && credit == FULL) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule
